// File: rtl/peripheral_master_ahb4.sv
// -----------------------------------------------------------------------------
// peripheral_master_ahb4
//
// AHB4-Lite master bridge. A simple valid/ready request port is turned into
// single (HBURST=SINGLE) AHB-Lite transfers. The address and data phases are
// pipelined, so a zero-wait slave sees one transfer per cycle. Every transfer
// produces exactly one response pulse, in issue order.
//
// Ports
//   HRESETn, HCLK            asynchronous active-low reset, rising-edge clock
//   req_*                    request port (req_i/req_ready_o handshake,
//                            write flag, address, size, prot, lock, wdata)
//   rsp_valid_o/err_o/rdata_o one-cycle response pulse per completed transfer
//   HADDR..HMASTLOCK         registered address-phase outputs
//   HWDATA                   registered data-phase write data
//   HRDATA, HREADY, HRESP    slave response inputs
// -----------------------------------------------------------------------------
module peripheral_master_ahb4 #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
) (
    input  logic            HRESETn,
    input  logic            HCLK,

    input  logic            req_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [PLEN-1:0] req_addr_i,
    input  logic [2:0]      req_size_i,
    input  logic [3:0]      req_prot_i,
    input  logic            req_lock_i,
    input  logic [XLEN-1:0] req_wdata_i,

    output logic            rsp_valid_o,
    output logic            rsp_err_o,
    output logic [XLEN-1:0] rsp_rdata_o,

    output logic [PLEN-1:0] HADDR,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Address stage: the HADDR..HMASTLOCK registers are the stage itself.
    logic            a_valid_q, a_valid_d;
    logic [PLEN-1:0] haddr_q, haddr_d;
    logic            hwrite_q, hwrite_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [3:0]      hprot_q, hprot_d;
    logic            hlock_q, hlock_d;
    logic [XLEN-1:0] a_wdata_q, a_wdata_d;
    logic [1:0]      htrans_q, htrans_d;

    // Data stage
    logic            d_valid_q, d_valid_d;
    logic            d_we_q, d_we_d;
    logic [XLEN-1:0] hwdata_q, hwdata_d;

    // Set between the two cycles of an ERROR response; blocks the address
    // stage so the pending request is re-presented after the error finishes.
    logic            err_hold_q, err_hold_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic a_done;
    logic d_done;

    assign req_ready_o = HRESETn & ~err_hold_q & (~a_valid_q | HREADY);

    always_comb begin
        accept      = req_i & req_ready_o;
        a_done      = a_valid_q & ~err_hold_q & HREADY;
        d_done      = d_valid_q & HREADY;

        a_valid_d   = a_valid_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hprot_d     = hprot_q;
        hlock_d     = hlock_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_we_d      = d_we_q;
        hwdata_d    = hwdata_q;
        err_hold_d  = err_hold_q;
        rsp_valid_d = d_done;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        // A new request may reload the stage on the same edge its previous
        // occupant moves on to the data phase.
        if (accept) begin
            a_valid_d = 1'b1;
            haddr_d   = req_addr_i;
            hwrite_d  = req_we_i;
            hsize_d   = req_size_i;
            hprot_d   = req_prot_i;
            hlock_d   = req_lock_i;
            a_wdata_d = req_wdata_i;
        end else if (a_done) begin
            a_valid_d = 1'b0;
        end

        if (a_done) begin
            d_valid_d = 1'b1;
            d_we_d    = hwrite_q;
            hwdata_d  = a_wdata_q;
        end else if (d_done) begin
            d_valid_d = 1'b0;
        end

        // First ERROR cycle (HREADY low) raises the hold; completion clears it.
        if (d_done) begin
            err_hold_d = 1'b0;
        end else if (d_valid_q & HRESP) begin
            err_hold_d = 1'b1;
        end

        if (d_done) begin
            rsp_err_d   = HRESP;
            rsp_rdata_d = d_we_q ? '0 : HRDATA;
        end

        htrans_d = (a_valid_d & ~err_hold_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_q   <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b010;
            hprot_q     <= 4'b0011;
            hlock_q     <= 1'b0;
            a_wdata_q   <= '0;
            htrans_q    <= HTRANS_IDLE;
            d_valid_q   <= 1'b0;
            d_we_q      <= 1'b0;
            hwdata_q    <= '0;
            err_hold_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hprot_q     <= hprot_d;
            hlock_q     <= hlock_d;
            a_wdata_q   <= a_wdata_d;
            htrans_q    <= htrans_d;
            d_valid_q   <= d_valid_d;
            d_we_q      <= d_we_d;
            hwdata_q    <= hwdata_d;
            err_hold_q  <= err_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HBURST      = 3'b000;
    assign HPROT       = hprot_q;
    assign HTRANS      = htrans_q;
    assign HMASTLOCK   = hlock_q;
    assign HWDATA      = hwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
